// File: rtl/tcam_pkg.sv
// Shared definitions for the ternary CAM array: FSM encoding and the
// priority / multi-hit helpers used on the registered match vector.
package tcam_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  // Helpers take a fixed-width vector; callers zero-extend their match vector.
  // CAM_DEPTH must not exceed this value.
  localparam int MAX_DEPTH = 256;

  // Index of the lowest set bit, 0 when the vector is empty.
  function automatic int lowest_set(input logic [MAX_DEPTH-1:0] vec);
    int idx;
    idx = 0;
    for (int i = MAX_DEPTH - 1; i >= 0; i--) begin
      if (vec[i]) idx = i;
    end
    return idx;
  endfunction

  // True when clearing the lowest set bit still leaves something set.
  function automatic logic multi_hit(input logic [MAX_DEPTH-1:0] vec);
    return (vec & (vec - MAX_DEPTH'(1))) != '0;
  endfunction

endpackage

// File: rtl/tcam_entry.sv
// One CAM row: stored data, stored don't-care mask and valid bit, plus the
// combinational ternary compare against the current search key.
module tcam_entry
  import tcam_pkg::*;
#(
  parameter int CAM_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [CAM_WIDTH-1:0] wr_data,
  input  logic [CAM_WIDTH-1:0] wr_mask,
  input  logic                 wr_valid,
  input  logic                 clear,
  input  logic [CAM_WIDTH-1:0] key,
  input  logic [CAM_WIDTH-1:0] search_mask,
  output logic                 match
);

  logic [CAM_WIDTH-1:0] data;
  logic [CAM_WIDTH-1:0] mask;
  logic                 valid;

  // Row storage; writes and flush clears never coincide because the top
  // blocks writes while a flush is running.
  always_ff @(posedge clk) begin
    if (!rst) begin
      data  <= '0;
      mask  <= '0;
      valid <= 1'b0;
    end else if (wr_en) begin
      data  <= wr_data;
      mask  <= wr_mask;
      valid <= wr_valid;
    end else if (clear) begin
      valid <= 1'b0;
    end
  end

  // A bit agrees if it is equal or ignored by either mask; invalid rows never hit.
  always_comb begin
    match = valid && (&(~(key ^ data) | mask | search_mask));
  end

endmodule

// File: rtl/tcam_array.sv
// Ternary CAM array with a 2-stage search pipeline, addressed writes and a
// sequential flush that clears one valid bit per cycle.
module tcam_array
  import tcam_pkg::*;
#(
  parameter int CAM_WIDTH  = 8,
  parameter int CAM_DEPTH  = 16,
  parameter int ADDR_WIDTH = $clog2(CAM_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [CAM_WIDTH-1:0]  wr_data,
  input  logic [CAM_WIDTH-1:0]  wr_mask,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic                  flush,
  input  logic                  search_req,
  input  logic [CAM_WIDTH-1:0]  search_key,
  input  logic [CAM_WIDTH-1:0]  search_mask,
  output logic                  search_ready,
  output logic                  result_valid,
  output logic                  result_hit,
  output logic [ADDR_WIDTH-1:0] result_addr,
  output logic                  result_multi,
  output logic [CAM_DEPTH-1:0]  match_vec
);

  state_t                state;
  state_t                next_state;
  logic [ADDR_WIDTH-1:0] flush_cnt;
  logic [ADDR_WIDTH-1:0] next_cnt;

  logic                  ready;
  logic                  wr_accept;
  logic                  search_accept;
  logic [CAM_DEPTH-1:0]  match_raw;

  logic                  s1_valid;
  logic [CAM_DEPTH-1:0]  s1_vec;

  assign ready         = (state == ST_IDLE);
  assign wr_ready      = ready;
  assign search_ready  = ready;
  assign wr_accept     = wr_en && ready;
  assign search_accept = search_req && ready;

  for (genvar i = 0; i < CAM_DEPTH; i++) begin : g_entry
    tcam_entry #(
      .CAM_WIDTH(CAM_WIDTH)
    ) u_entry (
      .clk        (clk),
      .rst        (rst),
      .wr_en      (wr_accept && (wr_addr == ADDR_WIDTH'(i))),
      .wr_data    (wr_data),
      .wr_mask    (wr_mask),
      .wr_valid   (wr_valid),
      .clear      ((state == ST_FLUSH) && (flush_cnt == ADDR_WIDTH'(i))),
      .key        (search_key),
      .search_mask(search_mask),
      .match      (match_raw[i])
    );
  end

  // Flush FSM state and sweep counter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= ST_IDLE;
      flush_cnt <= '0;
    end else begin
      state     <= next_state;
      flush_cnt <= next_cnt;
    end
  end

  // Next-state logic: flush in IDLE starts a sweep, flush during a sweep is ignored.
  always_comb begin
    next_state = state;
    next_cnt   = flush_cnt;
    case (state)
      ST_IDLE: begin
        if (flush) begin
          next_state = ST_FLUSH;
          next_cnt   = '0;
        end
      end
      ST_FLUSH: begin
        if (flush_cnt == ADDR_WIDTH'(CAM_DEPTH - 1)) begin
          next_state = ST_IDLE;
          next_cnt   = '0;
        end else begin
          next_cnt = flush_cnt + ADDR_WIDTH'(1);
        end
      end
      default: begin
        next_state = ST_IDLE;
        next_cnt   = '0;
      end
    endcase
  end

  // Search pipeline: stage 1 captures the raw matches, stage 2 encodes them;
  // result fields hold their last value between pulses.
  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_valid     <= 1'b0;
      s1_vec       <= '0;
      result_valid <= 1'b0;
      result_hit   <= 1'b0;
      result_addr  <= '0;
      result_multi <= 1'b0;
      match_vec    <= '0;
    end else begin
      s1_valid     <= search_accept;
      result_valid <= s1_valid;
      if (search_accept) begin
        s1_vec <= match_raw;
      end
      if (s1_valid) begin
        match_vec    <= s1_vec;
        result_hit   <= |s1_vec;
        result_addr  <= ADDR_WIDTH'(lowest_set(MAX_DEPTH'(s1_vec)));
        result_multi <= multi_hit(MAX_DEPTH'(s1_vec));
      end
    end
  end

endmodule

// File: tb/tb_tcam_array.sv
// Directed self-checking bench for tcam_array (8-bit x 16-entry build).
module tb_tcam_array;

  localparam int W  = 8;
  localparam int D  = 16;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [W-1:0]  wr_data = '0;
  logic [W-1:0]  wr_mask = '0;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic          flush = 1'b0;
  logic          search_req = 1'b0;
  logic [W-1:0]  search_key = '0;
  logic [W-1:0]  search_mask = '0;
  logic          search_ready;
  logic          result_valid;
  logic          result_hit;
  logic [AW-1:0] result_addr;
  logic          result_multi;
  logic [D-1:0]  match_vec;

  int total  = 0;
  int passed = 0;
  int failed = 0;

  tcam_array #(
    .CAM_WIDTH(W),
    .CAM_DEPTH(D)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_mask     (wr_mask),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .flush       (flush),
    .search_req  (search_req),
    .search_key  (search_key),
    .search_mask (search_mask),
    .search_ready(search_ready),
    .result_valid(result_valid),
    .result_hit  (result_hit),
    .result_addr (result_addr),
    .result_multi(result_multi),
    .match_vec   (match_vec)
  );

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  // Absolute time limit so the run can never hang.
  initial begin
    #50000;
    $display("[TB] FAIL watchdog: observed timeout expected finish");
    $fatal(1, "[TB] time limit reached");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_result(input string tag, input logic hit, input logic [AW-1:0] addr,
                              input logic multi, input logic [D-1:0] vec);
    check({tag, ".valid"}, 32'(result_valid), 32'(1'b1));
    check({tag, ".hit"},   32'(result_hit),   32'(hit));
    check({tag, ".addr"},  32'(result_addr),  32'(addr));
    check({tag, ".multi"}, 32'(result_multi), 32'(multi));
    check({tag, ".vec"},   32'(match_vec),    32'(vec));
  endtask

  task automatic write_entry(input logic [AW-1:0] a, input logic [W-1:0] d,
                             input logic [W-1:0] m, input logic v);
    wr_en    = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    wr_mask  = m;
    wr_valid = v;
    tick();
    wr_en = 1'b0;
  endtask

  // Issues one search and leaves the bench sampling just after the result edge.
  task automatic search(input string tag, input logic [W-1:0] key, input logic [W-1:0] mask);
    search_req  = 1'b1;
    search_key  = key;
    search_mask = mask;
    tick();
    search_req = 1'b0;
    check({tag, ".lat"}, 32'(result_valid), 32'(1'b0));
    tick();
  endtask

  // Linear directed sequence.
  initial begin
    int n;
    int pulses;
    logic last_hit;
    logic [AW-1:0] last_addr;

    $display("[TB] start");
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    check("rst.wr_ready",     32'(wr_ready),     32'(1'b1));
    check("rst.search_ready", 32'(search_ready), 32'(1'b1));
    check("rst.result_valid", 32'(result_valid), 32'(1'b0));
    check("rst.hit",          32'(result_hit),   32'(1'b0));
    check("rst.vec",          32'(match_vec),    32'(0));

    search("empty", 8'h00, 8'h00);
    check_result("empty", 1'b0, 4'd0, 1'b0, 16'h0000);

    write_entry(4'd3, 8'hA5, 8'h00, 1'b1);
    search("hit3", 8'hA5, 8'h00);
    check_result("hit3", 1'b1, 4'd3, 1'b0, 16'h0008);
    search("missA4", 8'hA4, 8'h00);
    check_result("missA4", 1'b0, 4'd0, 1'b0, 16'h0000);

    write_entry(4'd1, 8'hA0, 8'h0F, 1'b1);
    search("multi", 8'hA5, 8'h00);
    check_result("multi", 1'b1, 4'd1, 1'b1, 16'h000A);
    search("gmaskFF", 8'h12, 8'hFF);
    check_result("gmaskFF", 1'b1, 4'd1, 1'b1, 16'h000A);

    // Write and search to the same entry in one cycle: search sees old contents.
    wr_en       = 1'b1;
    wr_addr     = 4'd2;
    wr_data     = 8'h55;
    wr_mask     = 8'h00;
    wr_valid    = 1'b1;
    search_req  = 1'b1;
    search_key  = 8'h55;
    search_mask = 8'h00;
    tick();
    wr_en      = 1'b0;
    search_req = 1'b0;
    tick();
    check_result("samecyc", 1'b0, 4'd0, 1'b0, 16'h0000);
    search("after", 8'h55, 8'h00);
    check_result("after", 1'b1, 4'd2, 1'b0, 16'h0004);
    tick();
    check("hold.valid", 32'(result_valid), 32'(1'b0));
    check("hold.hit",   32'(result_hit),   32'(1'b1));
    check("hold.addr",  32'(result_addr),  32'(4'd2));

    write_entry(4'd2, 8'h55, 8'h00, 1'b0);
    search("inval", 8'h55, 8'h00);
    check_result("inval", 1'b0, 4'd0, 1'b0, 16'h0000);
    write_entry(4'd0, 8'h00, 8'hFF, 1'b0);
    search("inv_allmask", 8'h3C, 8'h00);
    check_result("inv_allmask", 1'b0, 4'd0, 1'b0, 16'h0000);

    for (int i = 0; i < D; i++) write_entry(AW'(i), W'(i), 8'h00, 1'b1);
    search("full7", 8'h07, 8'h00);
    check_result("full7", 1'b1, 4'd7, 1'b0, 16'h0080);
    search("full15", 8'h0F, 8'h00);
    check_result("full15", 1'b1, 4'd15, 1'b0, 16'h8000);
    search("fullall", 8'h00, 8'hFF);
    check_result("fullall", 1'b1, 4'd0, 1'b1, 16'hFFFF);
    search("bit1dc", 8'h05, 8'h02);
    check_result("bit1dc", 1'b1, 4'd5, 1'b1, 16'h00A0);

    // Flush together with a search: the search is accepted and completes during the sweep.
    flush       = 1'b1;
    search_req  = 1'b1;
    search_key  = 8'h07;
    search_mask = 8'h00;
    tick();
    flush      = 1'b0;
    search_req = 1'b0;
    check("flush.search_ready", 32'(search_ready), 32'(1'b0));
    check("flush.wr_ready",     32'(wr_ready),     32'(1'b0));
    n         = 0;
    pulses    = 0;
    last_hit  = 1'b0;
    last_addr = '0;
    while (search_ready === 1'b0 && n < 40) begin
      n++;
      if (n == 5) begin
        wr_en       = 1'b1;
        wr_addr     = 4'd0;
        wr_data     = 8'h33;
        wr_mask     = 8'h00;
        wr_valid    = 1'b1;
        search_req  = 1'b1;
        search_key  = 8'h33;
        search_mask = 8'h00;
      end
      if (n == 8) flush = 1'b1;
      tick();
      wr_en      = 1'b0;
      search_req = 1'b0;
      flush      = 1'b0;
      if (result_valid === 1'b1) begin
        pulses++;
        last_hit  = result_hit;
        last_addr = result_addr;
      end
    end
    check("flush.cycles",   32'(n),         32'(16));
    check("flush.pulses",   32'(pulses),    32'(1));
    check("flush.res_hit",  32'(last_hit),  32'(1'b1));
    check("flush.res_addr", 32'(last_addr), 32'(4'd7));
    check("flush.wr_ready_back", 32'(wr_ready), 32'(1'b1));
    search("postflush", 8'h33, 8'hFF);
    check_result("postflush", 1'b0, 4'd0, 1'b0, 16'h0000);

    // Back-to-back searches interrupted by a one-cycle reset.
    write_entry(4'd6, 8'h66, 8'h00, 1'b1);
    search_req  = 1'b1;
    search_key  = 8'h66;
    search_mask = 8'h00;
    tick();
    tick();
    check("stream.valid", 32'(result_valid), 32'(1'b1));
    check("stream.addr",  32'(result_addr),  32'(4'd6));
    rst = 1'b0;
    tick();
    rst        = 1'b1;
    search_req = 1'b0;
    check("midrst.valid", 32'(result_valid), 32'(1'b0));
    check("midrst.hit",   32'(result_hit),   32'(1'b0));
    check("midrst.vec",   32'(match_vec),    32'(0));
    tick();
    check("inflight1.valid", 32'(result_valid), 32'(1'b0));
    tick();
    check("inflight2.valid", 32'(result_valid), 32'(1'b0));
    search("postrst", 8'h66, 8'hFF);
    check_result("postrst", 1'b0, 4'd0, 1'b0, 16'h0000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
